sm_result_collector: RTL and testbench
======================================

Name: sm_result_collector

Overview:
- Drain side of the scoring datapath: captures per-toggle results (result0/result1 with vld0/vld1 and the matching id0/id1 from the target feeder) and pops the feeder's ID FIFOs.
- Converts biased scores to unsigned.
- Queues {lane, id, score} records in a show-ahead FIFO with a valid/ready output to the host.
- Tracks the best score seen.

Parameters:
- SCORE_WIDTH, 12, width of result and score.
- ID_WIDTH, 48, sequence ID width.
- ZERO, 2048 (2**(SCORE_WIDTH-1)), bias added to raw results.
- DEPTH, 8, result FIFO entries (power of 2).
- ADDR_WIDTH, 3, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- vld0  in  1  result0 valid from scoring module (level, may stay high several cycles).
- vld1  in  1  result1 valid from scoring module.
- result0  in  SCORE_WIDTH  signed biased score, toggle 0.
- result1  in  SCORE_WIDTH  signed biased score, toggle 1.
- id0  in  ID_WIDTH  head of feeder toggle-0 ID FIFO.
- id1  in  ID_WIDTH  head of feeder toggle-1 ID FIFO.
- re0  out  1  one-cycle pop of feeder toggle-0 ID FIFO.
- re1  out  1  one-cycle pop of feeder toggle-1 ID FIFO.
- out_valid  out  1  FIFO not empty; head record presented.
- out_ready  in  1  host accepts head record.
- out_lane  out  1  toggle the record came from.
- out_id  out  ID_WIDTH  sequence ID.
- out_score  out  SCORE_WIDTH  unbiased score.
- count  out  ADDR_WIDTH+1  FIFO occupancy.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a result was dropped.
- best_score  out  SCORE_WIDTH  maximum unbiased score written so far.
- best_id  out  ID_WIDTH  ID of best_score.
- clear  in  1  synchronous clear of best_score, best_id and overflow.

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, pend0/pend1 empty, edge-detect history regs 0.
- Edge detect: a capture event on lane L occurs at the clock edge where vldL=1 and its previous sample is 0. Level-high continuation is ignored.
- Capture at edge T on lane L:
  - pendL loads {L, idL, resultL+ZERO mod 2**SCORE_WIDTH}.
  - reL is registered high for exactly one cycle (T to T+1).
  - ID is sampled before the pop takes effect.
- Drop rule: a capture on lane L while pendL is still occupied is dropped. The existing pendL is kept, reL is still pulsed (keeps feeder ID FIFO aligned), and overflow is set.
- Arbiter:
  - Each cycle at most one pend is written to the FIFO, and only if !full.
  - pend0 has fixed priority over pend1.
  - A pend is freed on the edge its write occurs. A new capture in the same edge is legal and refills it.
- Latency: vld rising sampled at edge T; FIFO write at T+1 (no contention, not full); out_valid high after T+1. If both lanes capture at T: lane0 written at T+1, lane1 at T+2.
- FIFO:
  - Show-ahead; head on out_* whenever out_valid.
  - Pop when out_valid && out_ready.
  - Push is blocked when full even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Backpressure: while full, pends hold their contents. Further captures on occupied lanes become overflow drops.
- Best tracking:
  - On each FIFO write, if score > best_score, update best_score and best_id.
  - Ties keep the earlier entry.
- clear: best_score, best_id and overflow go to 0 at next edge. clear has priority over an update in the same cycle. FIFO contents are unaffected.

Test Plan:
- Single result: result0=-2043 (biased), id0=7, vld0 rising at T -> re0 one cycle; out_valid after T+1 with out_lane=0, out_id=7, out_score=5; best_score=5, best_id=7.
- Simultaneous lanes: vld0 and vld1 rise together, ids 3 and 4 -> re0 and re1 both pulse once; records read in order lane0/id3 then lane1/id4; count peaks at 2.
- Level hold: vld1 held high 10 cycles -> exactly one record, re1 pulses once.
- Fill and backpressure: out_ready=0, 9 lane-0 results spaced 2 cycles -> full=1 at count=8, ninth held in pend0; a tenth capture sets overflow=1 and is dropped. Then out_ready=1 -> ninth record drains, total 9 read.
- Best/tie/clear: scores 40, 90, 90(id9), 10 -> best_score=90 with first id. Pulse clear -> best_score=0, overflow=0, FIFO count unchanged.
- Reset mid-operation: rst=0 with count=5 and pend1 full -> out_valid=0, count=0, re0=re1=0 immediately; after release, a new result is captured normally.

Source files
------------

// File: rtl/sm_result_collector_if.sv
// Result stream from the collector to the host: show-ahead head record with valid/ready.
interface sm_result_collector_if #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48
);
    // A record transfers on every clock edge where out_valid && out_ready. While out_valid
    // is high the head record is held stable until it is accepted. out_valid never waits
    // for out_ready.
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_lane;
    logic [ID_WIDTH-1:0]    out_id;
    logic [SCORE_WIDTH-1:0] out_score;

    modport master (
        output out_valid,
        output out_lane,
        output out_id,
        output out_score,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_lane,
        input  out_id,
        input  out_score,
        output out_ready
    );
endinterface

// File: rtl/sm_result_collector.sv
// Drain side of the scoring datapath: captures per-toggle results, unbiases them and queues
// {lane, id, score} records for the host while tracking the best score seen.
module sm_result_collector #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int ZERO        = 2048,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld0,
    input  logic                   vld1,
    input  logic [SCORE_WIDTH-1:0] result0,
    input  logic [SCORE_WIDTH-1:0] result1,
    input  logic [ID_WIDTH-1:0]    id0,
    input  logic [ID_WIDTH-1:0]    id1,
    output logic                   re0,
    output logic                   re1,
    sm_result_collector_if.master  out,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   full,
    output logic                   overflow,
    output logic [SCORE_WIDTH-1:0] best_score,
    output logic [ID_WIDTH-1:0]    best_id,
    input  logic                   clear
);

    localparam logic [SCORE_WIDTH-1:0] BIAS      = SCORE_WIDTH'(ZERO);
    localparam logic [ADDR_WIDTH:0]    DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]    ONE_CNT   = (ADDR_WIDTH+1)'(1);

    typedef struct packed {
        logic                   lane;
        logic [ID_WIDTH-1:0]    id;
        logic [SCORE_WIDTH-1:0] score;
    } rec_t;

    logic vld0_q, vld1_q;
    logic cap0, cap1;
    logic pend0_v, pend1_v;
    rec_t pend0, pend1;
    logic wr0, wr1, push, pop;
    logic load0, load1, drop0, drop1;
    rec_t push_rec, head;

    rec_t                  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, rptr;

    assign cap0 = vld0 & ~vld0_q;
    assign cap1 = vld1 & ~vld1_q;

    // Lane 0 has fixed priority; nothing enters the FIFO while full, even if a pop is pending.
    assign wr0      = pend0_v & ~full;
    assign wr1      = pend1_v & ~pend0_v & ~full;
    assign push     = wr0 | wr1;
    assign push_rec = wr0 ? pend0 : pend1;

    // A pend being written on this edge is free again, so a same-edge capture refills it.
    assign load0 = cap0 & (~pend0_v | wr0);
    assign load1 = cap1 & (~pend1_v | wr1);
    assign drop0 = cap0 & pend0_v & ~wr0;
    assign drop1 = cap1 & pend1_v & ~wr1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            re0     <= 1'b0;
            re1     <= 1'b0;
            pend0_v <= 1'b0;
            pend1_v <= 1'b0;
            pend0   <= '0;
            pend1   <= '0;
        end else begin
            vld0_q <= vld0;
            vld1_q <= vld1;
            // Dropped captures still pop the feeder so its ID FIFO stays aligned with results.
            re0    <= cap0;
            re1    <= cap1;
            if (load0) begin
                pend0_v     <= 1'b1;
                pend0.lane  <= 1'b0;
                pend0.id    <= id0;
                pend0.score <= result0 + BIAS;
            end else if (wr0) begin
                pend0_v <= 1'b0;
            end
            if (load1) begin
                pend1_v     <= 1'b1;
                pend1.lane  <= 1'b1;
                pend1.id    <= id1;
                pend1.score <= result1 + BIAS;
            end else if (wr1) begin
                pend1_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_rec;
        end
    end

    assign pop = out.out_valid & out.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    assign full = (count == DEPTH_CNT);
    assign head = mem[rptr];

    assign out.out_valid = (count != '0);
    assign out.out_lane  = out.out_valid ? head.lane  : 1'b0;
    assign out.out_id    = out.out_valid ? head.id    : '0;
    assign out.out_score = out.out_valid ? head.score : '0;

    // Strict greater-than keeps the earlier record on ties; clear wins over a same-cycle update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_score <= '0;
            best_id    <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            best_score <= '0;
            best_id    <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push && (push_rec.score > best_score)) begin
                best_score <= push_rec.score;
                best_id    <= push_rec.id;
            end
            if (drop0 | drop1) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sm_result_collector.sv
// Self-checking bench for sm_result_collector: vector table, hand-written corner sequences
// and a record scoreboard on the output stream.
module tb_sm_result_collector;

    localparam int SW    = 12;
    localparam int IW    = 48;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RW    = 1 + IW + SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld0, vld1;
    logic [SW-1:0] result0, result1;
    logic [IW-1:0] id0, id1;
    logic          re0, re1;
    logic [AW:0]   count;
    logic          full, overflow;
    logic [SW-1:0] best_score;
    logic [IW-1:0] best_id;
    logic          clear;

    sm_result_collector_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IW)) bus ();

    sm_result_collector #(
        .SCORE_WIDTH(SW), .ID_WIDTH(IW), .ZERO(2048), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .vld0(vld0), .vld1(vld1),
        .result0(result0), .result1(result1),
        .id0(id0), .id1(id1),
        .re0(re0), .re1(re1),
        .out(bus),
        .count(count), .full(full), .overflow(overflow),
        .best_score(best_score), .best_id(best_id),
        .clear(clear)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int n_read = 0;

    typedef struct {
        bit            lane;
        logic [SW-1:0] res;
        logic [IW-1:0] id;
        logic [SW-1:0] exp_score;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_rec(input bit lane, input logic [IW-1:0] id,
                                             input logic [SW-1:0] score);
        return {lane, id, score};
    endfunction

    // Records leave on the edge after a negedge where valid && ready.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.out_valid && bus.out_ready) begin
            n_read++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rec_unexpected: got %0h expected none",
                         {bus.out_lane, bus.out_id, bus.out_score});
            end else begin
                check("rec", {bus.out_lane, bus.out_id, bus.out_score}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising vld for one cycle on one lane; checks the one-cycle feeder pop.
    task automatic pulse(input bit lane, input logic [SW-1:0] res, input logic [IW-1:0] id);
        if (lane == 1'b0) begin
            result0 = res; id0 = id; vld0 = 1'b1;
        end else begin
            result1 = res; id1 = id; vld1 = 1'b1;
        end
        tick();
        check(lane ? "re1_pulse" : "re0_pulse", lane ? re1 : re0, 1);
        vld0 = 1'b0;
        vld1 = 1'b0;
        tick();
        check(lane ? "re1_low" : "re0_low", lane ? re1 : re0, 0);
    endtask

    task automatic drain(input int max_cyc);
        int i = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && i < max_cyc) begin
            tick();
            i++;
        end
        check("drain_done", (exp_q.size() == 0 && !bus.out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int pulses;
        int bs[4];
        int bi[4];

        vecs[0] = '{1'b0, 12'h000, 48'h11,           12'd2048};
        vecs[1] = '{1'b1, 12'h7FF, 48'h22,           12'd4095};
        vecs[2] = '{1'b0, 12'h800, 48'h33,           12'd0};
        vecs[3] = '{1'b1, 12'hFFF, 48'h44,           12'd2047};
        vecs[4] = '{1'b0, 12'd100, 48'hABCDEF012345, 12'd2148};
        vecs[5] = '{1'b1, 12'hF9C, 48'h66,           12'd1948};

        rst = 1'b0; vld0 = 1'b0; vld1 = 1'b0; result0 = '0; result1 = '0;
        id0 = '0; id1 = '0; clear = 1'b0; bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_best", {best_score, best_id}, 0);
        check("rst_re", {re0, re1}, 0);
        rst = 1'b1;
        tick();

        // Single result: -2043 biased becomes 5.
        exp_q.push_back(mk_rec(1'b0, 48'd7, 12'd5));
        pulse(1'b0, 12'h805, 48'd7);
        check("single_valid", bus.out_valid, 1);
        check("single_count", count, 1);
        check("single_head", {bus.out_lane, bus.out_id, bus.out_score}, mk_rec(1'b0, 48'd7, 12'd5));
        check("single_best_score", best_score, 5);
        check("single_best_id", best_id, 7);
        drain(10);

        // Table of vectors with streaming output.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk_rec(vecs[i].lane, vecs[i].id, vecs[i].exp_score));
            pulse(vecs[i].lane, vecs[i].res, vecs[i].id);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain(20);
        check("table_best_score", best_score, 4095);
        check("table_best_id", best_id, 48'h22);

        // Both lanes capture on the same edge.
        bus.out_ready = 1'b0;
        exp_q.push_back(mk_rec(1'b0, 48'd3, 12'd2058));
        exp_q.push_back(mk_rec(1'b1, 48'd4, 12'd2068));
        result0 = 12'd10; id0 = 48'd3; result1 = 12'd20; id1 = 48'd4;
        vld0 = 1'b1; vld1 = 1'b1;
        tick();
        check("sim_re", {re0, re1}, 2'b11);
        check("sim_count_t", count, 0);
        tick();
        check("sim_count_t1", count, 1);
        check("sim_re_low", {re0, re1}, 2'b00);
        vld0 = 1'b0; vld1 = 1'b0;
        tick();
        check("sim_count_t2", count, 2);
        tick();
        check("sim_count_peak", count, 2);
        drain(10);

        // Level hold on lane 1 yields one record.
        r0 = n_read;
        pulses = 0;
        exp_q.push_back(mk_rec(1'b1, 48'd77, 12'd2098));
        result1 = 12'd50; id1 = 48'd77; vld1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(re1);
        end
        vld1 = 1'b0;
        tick();
        pulses += int'(re1);
        check("level_re1_pulses", pulses, 1);
        drain(10);
        check("level_reads", n_read - r0, 1);

        // Fill, hold the ninth in pend0, drop the tenth.
        bus.out_ready = 1'b0;
        r0 = n_read;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(mk_rec(1'b0, IW'(100 + k), SW'(k)));
            pulse(1'b0, SW'(k + 2048), IW'(100 + k));
        end
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        check("fill_no_overflow", overflow, 0);
        pulse(1'b0, 12'd5, 48'd200);
        check("fill_overflow", overflow, 1);
        check("fill_count_hold", count, 8);
        drain(40);
        check("fill_reads", n_read - r0, 9);
        check("fill_empty", count, 0);

        // Best tracking, ties and clear.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_best", {best_score, best_id}, 0);
        check("clr_overflow", overflow, 0);
        bus.out_ready = 1'b0;
        bs = '{40, 90, 90, 10};
        bi = '{5, 8, 9, 23};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk_rec(1'b0, IW'(bi[i]), SW'(bs[i])));
            pulse(1'b0, SW'(bs[i] + 2048), IW'(bi[i]));
        end
        check("tie_best_score", best_score, 90);
        check("tie_best_id", best_id, 8);
        check("tie_count", count, 4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_best", {best_score, best_id}, 0);
        check("clear_count", count, 4);
        exp_q.push_back(mk_rec(1'b1, 48'd50, 12'd500));
        result1 = SW'(500 + 2048); id1 = 48'd50; vld1 = 1'b1;
        tick();
        vld1 = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_prio_best", best_score, 0);
        check("clear_prio_count", count, 5);
        drain(20);

        // Reset mid-operation with pend1 occupied.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pulse(1'b0, SW'(k), IW'(k));
        end
        check("mid_count", count, 5);
        result1 = 12'd1; id1 = 48'd300; vld1 = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_re", {re0, re1}, 0);
        exp_q.delete();
        vld1 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_count", count, 0);
        exp_q.push_back(mk_rec(1'b0, 48'd99, 12'd2048));
        bus.out_ready = 1'b1;
        pulse(1'b0, 12'd0, 48'd99);
        drain(10);
        check("post_rst_best", {best_score, best_id}, {12'd2048, 48'd99});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
